spi_reg_ctrl: RTL and testbench

Transaction controller behind the SPI slave byte interface. It parses the received byte stream into command/data phases, sequences reads and writes on a local register-access port, and supplies the next byte for the slave to shift out on MISO. It sits between the SPI byte shifter and the design's control/status register bank, so the host can read and write registers with framed SPI transfers.

---
 rtl/spi_reg_ctrl_if.sv | 27 ++
 rtl/spi_reg_ctrl.sv | 132 +++++++++++++
 tb/tb_spi_reg_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_ctrl_if.sv
// Byte-level link between the SPI shifter, the transaction controller and the register bank.
// The master side is the environment around the controller, and the slave side is the controller itself.
interface spi_reg_ctrl_if #(
    parameter int AW = 4
);
    logic          ss_active;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic [7:0]    tx_byte;
    logic [AW-1:0] reg_addr;
    logic [7:0]    reg_wdata;
    logic          reg_we;
    logic          reg_re;
    logic [7:0]    reg_rdata;
    logic          cmd_err;
    logic          busy;

    modport master (
        output ss_active, rx_valid, rx_byte, reg_rdata,
        input  tx_byte, reg_addr, reg_wdata, reg_we, reg_re, cmd_err, busy
    );

    modport slave (
        input  ss_active, rx_valid, rx_byte, reg_rdata,
        output tx_byte, reg_addr, reg_wdata, reg_we, reg_re, cmd_err, busy
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI transaction controller: decodes the command byte, then streams register reads/writes
// with optional auto-increment, and prefetches read data into the next outgoing byte.
module spi_reg_ctrl #(
    parameter int          NREG    = 16,
    parameter int          AW      = 4,
    parameter logic [7:0]  ID_BYTE = 8'hA5
) (
    input logic           clk,
    input logic           rst,
    spi_reg_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        RD_WAIT,
        READ,
        WRITE,
        DISCARD
    } state_t;

    localparam logic [AW-1:0] ADDR_LAST = AW'(NREG - 1);

    state_t        state, state_n;
    logic          ss_prev;
    logic [AW-1:0] addr, addr_n, addr_inc;
    logic          inc, inc_n;
    logic [7:0]    tx, tx_n;
    logic [7:0]    wdata, wdata_n;
    logic          we, we_n;
    logic          re, re_n;
    logic          err, err_n;

    assign addr_inc = (addr == ADDR_LAST) ? '0 : addr + 1'b1;

    // ss_prev resets high so a frame already in progress at reset is not mistaken for a new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ss_prev <= 1'b1;
            addr    <= '0;
            inc     <= 1'b0;
            tx      <= ID_BYTE;
            wdata   <= 8'h00;
            we      <= 1'b0;
            re      <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            ss_prev <= bus.ss_active;
            addr    <= addr_n;
            inc     <= inc_n;
            tx      <= tx_n;
            wdata   <= wdata_n;
            we      <= we_n;
            re      <= re_n;
            err     <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = addr;
        inc_n   = inc;
        tx_n    = tx;
        wdata_n = wdata;
        we_n    = 1'b0;
        re_n    = 1'b0;
        err_n   = 1'b0;

        if (!bus.ss_active) begin
            state_n = IDLE;
            tx_n    = ID_BYTE;
        end else begin
            case (state)
                IDLE: begin
                    if (!ss_prev) state_n = CMD;
                end
                CMD: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_byte[5:4] != 2'b00) begin
                            err_n   = 1'b1;
                            state_n = DISCARD;
                        end else begin
                            addr_n = bus.rx_byte[AW-1:0];
                            inc_n  = bus.rx_byte[6];
                            if (bus.rx_byte[7]) begin
                                re_n    = 1'b1;
                                state_n = RD_WAIT;
                            end else begin
                                state_n = WRITE;
                            end
                        end
                    end
                end
                // The first RD_WAIT cycle has reg_re high; the bank answers in the second one.
                RD_WAIT: begin
                    if (!re) begin
                        tx_n    = bus.reg_rdata;
                        state_n = READ;
                    end
                end
                READ: begin
                    if (bus.rx_valid) begin
                        if (inc) addr_n = addr_inc;
                        re_n    = 1'b1;
                        state_n = RD_WAIT;
                    end
                end
                WRITE: begin
                    if (we && inc) addr_n = addr_inc;
                    if (bus.rx_valid) begin
                        we_n    = 1'b1;
                        wdata_n = bus.rx_byte;
                    end
                end
                DISCARD: begin
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.tx_byte   = tx;
    assign bus.reg_addr  = addr;
    assign bus.reg_wdata = wdata;
    assign bus.reg_we    = we;
    assign bus.reg_re    = re;
    assign bus.cmd_err   = err;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: a frame-level model predicts strobes, tx_byte and busy per cycle,
// and literal expectations pin the model on the key scenarios.
module tb_spi_reg_ctrl;

    localparam logic [7:0] ID = 8'hA5;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   failures;
    bit   chk_en;

    spi_reg_ctrl_if #(.AW(4)) bus ();

    spi_reg_ctrl #(.NREG(16), .AW(4), .ID_BYTE(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: per-cycle expectations keyed by cycle number
    int         we_at   [int];
    logic [7:0] wd_at   [int];
    int         re_at   [int];
    bit         err_at  [int];
    logic [7:0] tx_at   [int];
    bit         busy_at [int];
    int         phase;
    int         m_addr;
    bit         m_inc;
    bit         m_prev;
    logic [7:0] exp_tx;
    bit         exp_busy;

    // Observed traffic, collected for the literal checks
    int obs_we_addr[$];
    int obs_we_data[$];
    int obs_re_addr[$];
    int err_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register bank: data is valid only in the cycle after reg_re, garbage otherwise.
    always @(posedge clk) begin : bank
        logic       re_s;
        logic [3:0] a_s;
        re_s = bus.reg_re;
        a_s  = bus.reg_addr;
        #1 bus.reg_rdata = re_s ? (8'h50 + {4'h0, a_s}) : 8'hEE;
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: actual=%02h required=%02h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expectRead(input int k);
        re_at[k+1] = m_addr;
        tx_at[k+3] = 8'h50 + 8'(m_addr);
    endtask

    task automatic modelStep(input logic r, input logic ss, input logic rxv, input logic [7:0] b,
                             input int k);
        if (r) begin
            for (int j = 1; j <= 3; j++) if (tx_at.exists(k + j)) tx_at.delete(k + j);
            tx_at[k+1]   = ID;
            busy_at[k+1] = 1'b0;
            phase        = 0;
            m_prev       = 1'b1;
        end else begin
            if (!ss) begin
                if (m_prev) begin
                    for (int j = 1; j <= 3; j++) if (tx_at.exists(k + j)) tx_at.delete(k + j);
                    tx_at[k+1]   = ID;
                    busy_at[k+1] = 1'b0;
                end
                phase = 0;
            end else begin
                if (rxv) begin
                    case (phase)
                        1: begin
                            if (b[5:4] != 2'b00) begin
                                err_at[k+1] = 1'b1;
                                phase       = 4;
                            end else begin
                                m_addr = int'(b[3:0]);
                                m_inc  = b[6];
                                if (b[7]) begin
                                    phase = 2;
                                    expectRead(k);
                                end else begin
                                    phase = 3;
                                end
                            end
                        end
                        2: begin
                            if (m_inc) m_addr = (m_addr + 1) % 16;
                            expectRead(k);
                        end
                        3: begin
                            we_at[k+1] = m_addr;
                            wd_at[k+1] = b;
                            if (m_inc) m_addr = (m_addr + 1) % 16;
                        end
                        default: ;
                    endcase
                end
                if (!m_prev) begin
                    phase        = 1;
                    busy_at[k+1] = 1'b1;
                end
            end
            m_prev = ss;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ss, input logic rxv, input logic [7:0] b);
        rst           = r;
        bus.ss_active = ss;
        bus.rx_valid  = rxv;
        bus.rx_byte   = b;
        modelStep(r, ss, rxv, b, cyc);
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n, input logic ss);
        repeat (n) applyStimulus(1'b0, ss, 1'b0, 8'h00);
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(1'b0, 1'b1, 1'b1, b);
        idleCycles(7, 1'b1);
    endtask

    task automatic openFrame();
        obs_we_addr.delete();
        obs_we_data.delete();
        obs_re_addr.delete();
        err_cnt = 0;
        idleCycles(3, 1'b1);
    endtask

    task automatic closeFrame();
        idleCycles(4, 1'b0);
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            if (tx_at.exists(cyc)) exp_tx = tx_at[cyc];
            if (busy_at.exists(cyc)) exp_busy = busy_at[cyc];
            checkOutput("tx_byte", bus.tx_byte, exp_tx);
            checkOutput("busy", {7'b0, bus.busy}, {7'b0, exp_busy});
            checkOutput("reg_we", {7'b0, bus.reg_we}, {7'b0, we_at.exists(cyc)});
            checkOutput("reg_re", {7'b0, bus.reg_re}, {7'b0, re_at.exists(cyc)});
            checkOutput("cmd_err", {7'b0, bus.cmd_err}, {7'b0, err_at.exists(cyc)});
            if (we_at.exists(cyc)) begin
                checkOutput("we_addr", {4'h0, bus.reg_addr}, 8'(we_at[cyc]));
                checkOutput("we_data", bus.reg_wdata, wd_at[cyc]);
            end
            if (re_at.exists(cyc)) checkOutput("re_addr", {4'h0, bus.reg_addr}, 8'(re_at[cyc]));
            if (bus.reg_we) begin
                obs_we_addr.push_back(int'(bus.reg_addr));
                obs_we_data.push_back(int'(bus.reg_wdata));
            end
            if (bus.reg_re) obs_re_addr.push_back(int'(bus.reg_addr));
            if (bus.cmd_err) err_cnt++;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0; failures = 0; chk_en = 1'b0; cyc = 0; err_cnt = 0;
        rst = 1'b1;
        bus.ss_active = 1'b0; bus.rx_valid = 1'b0; bus.rx_byte = 8'h00; bus.reg_rdata = 8'hEE;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        phase = 0; m_addr = 0; m_inc = 1'b0; m_prev = 1'b1;
        exp_tx = ID; exp_busy = 1'b0;
        chk_en = 1'b1;

        $display("[TB] reset state");
        checkOutput("rst_tx", bus.tx_byte, 8'hA5);
        checkOutput("rst_busy", {7'b0, bus.busy}, 8'h00);
        checkOutput("rst_we", {7'b0, bus.reg_we}, 8'h00);
        checkOutput("rst_re", {7'b0, bus.reg_re}, 8'h00);
        checkOutput("rst_err", {7'b0, bus.cmd_err}, 8'h00);
        checkOutput("rst_addr", {4'h0, bus.reg_addr}, 8'h00);
        checkOutput("rst_wdata", bus.reg_wdata, 8'h00);
        idleCycles(4, 1'b0);

        $display("[TB] write frame 43 11 22");
        openFrame();
        checkOutput("wr_busy", {7'b0, bus.busy}, 8'h01);
        sendByte(8'h43); sendByte(8'h11); sendByte(8'h22);
        closeFrame();
        checkOutput("wr_count", 8'(obs_we_addr.size()), 8'd2);
        if (obs_we_addr.size() == 2) begin
            checkOutput("wr0_addr", 8'(obs_we_addr[0]), 8'h03);
            checkOutput("wr0_data", 8'(obs_we_data[0]), 8'h11);
            checkOutput("wr1_addr", 8'(obs_we_addr[1]), 8'h04);
            checkOutput("wr1_data", 8'(obs_we_data[1]), 8'h22);
        end
        checkOutput("wr_busy_end", {7'b0, bus.busy}, 8'h00);

        $display("[TB] read frame CF with wrap");
        openFrame();
        sendByte(8'hCF); checkOutput("rd_tx0", bus.tx_byte, 8'h5F);
        sendByte(8'h00); checkOutput("rd_tx1", bus.tx_byte, 8'h50);
        sendByte(8'h00); checkOutput("rd_tx2", bus.tx_byte, 8'h51);
        closeFrame();
        checkOutput("rd_tx_idle", bus.tx_byte, 8'hA5);
        checkOutput("rd_count", 8'(obs_re_addr.size()), 8'd3);
        if (obs_re_addr.size() == 3) begin
            checkOutput("rd0_addr", 8'(obs_re_addr[0]), 8'h0F);
            checkOutput("rd1_addr", 8'(obs_re_addr[1]), 8'h00);
            checkOutput("rd2_addr", 8'(obs_re_addr[2]), 8'h01);
        end

        $display("[TB] read frame 82 without increment");
        openFrame();
        sendByte(8'h82);
        for (int i = 0; i < 3; i++) begin
            sendByte(8'hFF);
            checkOutput("rdh_tx", bus.tx_byte, 8'h52);
        end
        closeFrame();
        checkOutput("rdh_count", 8'(obs_re_addr.size()), 8'd4);
        foreach (obs_re_addr[i]) checkOutput("rdh_addr", 8'(obs_re_addr[i]), 8'h02);

        $display("[TB] illegal command 12");
        openFrame();
        sendByte(8'h12); sendByte(8'h80); sendByte(8'h01);
        checkOutput("err_busy", {7'b0, bus.busy}, 8'h01);
        closeFrame();
        checkOutput("err_count", 8'(err_cnt), 8'd1);
        checkOutput("err_we", 8'(obs_we_addr.size()), 8'd0);
        checkOutput("err_re", 8'(obs_re_addr.size()), 8'd0);
        checkOutput("err_busy_end", {7'b0, bus.busy}, 8'h00);

        $display("[TB] select drop with data byte");
        openFrame();
        sendByte(8'h05); sendByte(8'h77);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h99);
        idleCycles(4, 1'b0);
        checkOutput("drop_count", 8'(obs_we_addr.size()), 8'd1);
        if (obs_we_addr.size() == 1) checkOutput("drop_data", 8'(obs_we_data[0]), 8'h77);

        $display("[TB] reset mid-frame");
        openFrame();
        sendByte(8'h4A); sendByte(8'h01);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("mrst_tx", bus.tx_byte, 8'hA5);
        checkOutput("mrst_busy", {7'b0, bus.busy}, 8'h00);
        checkOutput("mrst_addr", {4'h0, bus.reg_addr}, 8'h00);
        checkOutput("mrst_wdata", bus.reg_wdata, 8'h00);
        sendByte(8'h02);
        checkOutput("mrst_idle", {7'b0, bus.busy}, 8'h00);
        checkOutput("mrst_count", 8'(obs_we_addr.size()), 8'd1);
        idleCycles(3, 1'b0);
        openFrame();
        sendByte(8'h41); sendByte(8'h33);
        closeFrame();
        checkOutput("post_count", 8'(obs_we_addr.size()), 8'd1);
        if (obs_we_addr.size() == 1) begin
            checkOutput("post_addr", 8'(obs_we_addr[0]), 8'h01);
            checkOutput("post_data", 8'(obs_we_data[0]), 8'h33);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
